// File: rtl/sdram_pkg.sv
// Shared encodings for the SDRAM command decoder: bus commands, FSM states,
// error causes and the mode-register decode helpers.
package sdram_pkg;

  // {CS,RAS,CAS,WE}; any command with CS high is a deselect
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REF  = 4'b0001;
  localparam logic [3:0] CMD_MRSET     = 4'b0000;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;

  typedef enum logic [2:0] {
    ST_WAIT_PWR = 3'd0,
    ST_WAIT_PRE = 3'd1,
    ST_WAIT_REF = 3'd2,
    ST_WAIT_MRS = 3'd3,
    ST_WAIT_MRD = 3'd4,
    ST_READY    = 3'd5,
    ST_ERROR    = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE        = 3'd0,
    ERR_EARLY_CMD   = 3'd1,
    ERR_A10_LOW     = 3'd2,
    ERR_ILLEGAL_CMD = 3'd3,
    ERR_TIMING      = 3'd4,
    ERR_SHORT_REF   = 3'd5,
    ERR_BAD_MODE    = 3'd6
  } err_t;

  function automatic logic is_nop(input logic [3:0] cmd);
    return cmd[3] || (cmd == CMD_NOP);
  endfunction

  function automatic logic mode_ok(input logic [11:0] addr);
    logic cas_ok;
    logic bl_ok;
    cas_ok = (addr[6:4] == 3'd2) || (addr[6:4] == 3'd3);
    bl_ok  = (addr[2] == 1'b0) || (addr[2:0] == 3'b111);
    return cas_ok && bl_ok && !addr[3];
  endfunction

  function automatic logic [3:0] burst_decode(input logic [2:0] code);
    case (code)
      3'b000:  return 4'd1;
      3'b001:  return 4'd2;
      3'b010:  return 4'd4;
      3'b011:  return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/sdram_timer.sv
// Down-counting command-spacing timer; loaded with (T-1), frozen while hold is high.
module sdram_timer #(
  parameter int W = 3
) (
  input  logic         sclk,
  input  logic         s_rst,
  input  logic         load,
  input  logic         hold,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (!hold && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sdram_cmd_decoder.sv
// Watches the controller's SDRAM command bus, checks the power-up/init sequence
// and command spacing, and decodes the programmed mode register.
module sdram_cmd_decoder
  import sdram_pkg::*;
#(
  parameter int CNT_200US = 10000,
  parameter int T_RP      = 2,
  parameter int T_RFC     = 7,
  parameter int T_MRD     = 2,
  parameter int NUM_REF   = 2
) (
  input  logic        sclk,
  input  logic        s_rst,
  input  logic        sdram_cke,
  input  logic [3:0]  sdram_cmd,
  input  logic [11:0] sdram_addr,
  input  logic [1:0]  sdram_bank,
  output logic        init_done,
  output logic [11:0] mode_reg,
  output logic [2:0]  cas_lat,
  output logic [3:0]  burst_len,
  output logic [7:0]  ref_cnt,
  output logic        proto_err,
  output logic [2:0]  err_code,
  output logic [2:0]  state
);

  localparam int PW   = $clog2(CNT_200US + 1);
  localparam int TMAX = (T_RP > T_RFC) ? ((T_RP > T_MRD) ? T_RP : T_MRD)
                                       : ((T_RFC > T_MRD) ? T_RFC : T_MRD);
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  state_t          cur_state, next_state;
  err_t            fault;
  logic [PW-1:0]   pwr_cnt;
  logic [7:0]      init_refs;
  logic            pwr_inc, init_ref_inc, ref_inc, mode_load;
  logic            tmr_load, tmr_zero;
  logic [TW-1:0]   tmr_val;
  logic [1:0]      bank_unused;

  // Bank address plays no part in initialisation or mode decoding
  assign bank_unused = sdram_bank;

  sdram_timer #(.W(TW)) u_timer (
    .sclk     (sclk),
    .s_rst    (s_rst),
    .load     (tmr_load),
    .hold     (!sdram_cke),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      cur_state <= ST_WAIT_PWR;
      pwr_cnt   <= '0;
      init_refs <= '0;
      err_code  <= '0;
      mode_reg  <= '0;
      cas_lat   <= '0;
      burst_len <= '0;
      ref_cnt   <= '0;
      init_done <= 1'b0;
    end else begin
      cur_state <= next_state;
      init_done <= (cur_state == ST_READY) && (next_state == ST_READY);
      if (fault != ERR_NONE) err_code <= fault;
      if (pwr_inc) pwr_cnt <= pwr_cnt + 1'b1;
      if (init_ref_inc) init_refs <= init_refs + 1'b1;
      if (ref_inc && (ref_cnt != 8'hFF)) ref_cnt <= ref_cnt + 1'b1;
      if (mode_load) begin
        mode_reg  <= sdram_addr;
        cas_lat   <= sdram_addr[6:4];
        burst_len <= burst_decode(sdram_addr[2:0]);
      end
    end
  end

  // A violation always wins over whatever legal action the same command implied
  always_comb begin
    next_state   = cur_state;
    fault        = ERR_NONE;
    pwr_inc      = 1'b0;
    init_ref_inc = 1'b0;
    ref_inc      = 1'b0;
    mode_load    = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    if (sdram_cke && (cur_state != ST_ERROR)) begin
      if (cur_state == ST_WAIT_PWR) begin
        if (!is_nop(sdram_cmd)) begin
          fault = ERR_EARLY_CMD;
        end else begin
          pwr_inc = 1'b1;
          if (pwr_cnt == PW'(CNT_200US - 1)) next_state = ST_WAIT_PRE;
        end
      end else if (!is_nop(sdram_cmd)) begin
        if (!tmr_zero) begin
          fault = ERR_TIMING;
        end else begin
          case (cur_state)
            ST_WAIT_PRE: begin
              if (sdram_cmd != CMD_PRECHARGE) fault = ERR_ILLEGAL_CMD;
              else if (!sdram_addr[10])       fault = ERR_A10_LOW;
              else begin
                tmr_load   = 1'b1;
                tmr_val    = TW'(T_RP - 1);
                next_state = ST_WAIT_REF;
              end
            end
            ST_WAIT_REF: begin
              if (sdram_cmd == CMD_AUTO_REF) begin
                init_ref_inc = 1'b1;
                tmr_load     = 1'b1;
                tmr_val      = TW'(T_RFC - 1);
                if (init_refs == 8'(NUM_REF - 1)) next_state = ST_WAIT_MRS;
              end else if (sdram_cmd == CMD_MRSET) begin
                fault = ERR_SHORT_REF;
              end else begin
                fault = ERR_ILLEGAL_CMD;
              end
            end
            ST_WAIT_MRS: begin
              if (sdram_cmd == CMD_AUTO_REF) begin
                tmr_load = 1'b1;
                tmr_val  = TW'(T_RFC - 1);
              end else if (sdram_cmd == CMD_MRSET) begin
                if (!mode_ok(sdram_addr)) fault = ERR_BAD_MODE;
                else begin
                  mode_load  = 1'b1;
                  tmr_load   = 1'b1;
                  tmr_val    = TW'(T_MRD - 1);
                  next_state = ST_WAIT_MRD;
                end
              end else begin
                fault = ERR_ILLEGAL_CMD;
              end
            end
            ST_WAIT_MRD, ST_READY: begin
              // Once tMRD has expired a command behaves exactly as in READY
              next_state = ST_READY;
              case (sdram_cmd)
                CMD_AUTO_REF: begin
                  ref_inc  = 1'b1;
                  tmr_load = 1'b1;
                  tmr_val  = TW'(T_RFC - 1);
                end
                CMD_PRECHARGE: begin
                  tmr_load = 1'b1;
                  tmr_val  = TW'(T_RP - 1);
                end
                CMD_MRSET: begin
                  if (!mode_ok(sdram_addr)) fault = ERR_BAD_MODE;
                  else begin
                    mode_load = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_val   = TW'(T_MRD - 1);
                  end
                end
                default: ;
              endcase
            end
            default: ;
          endcase
        end
      end else if ((cur_state == ST_WAIT_MRD) && tmr_zero) begin
        next_state = ST_READY;
      end
      if (fault != ERR_NONE) next_state = ST_ERROR;
    end
  end

  always_comb begin
    state     = cur_state;
    proto_err = (cur_state == ST_ERROR);
  end

endmodule
